// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Port 0 is the fetch path, port 1 the data-read path.
package imem_arb_pkg;

  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester, memory and debug signals shared between the arbiter and its environment.
// slave is the arbiter's view; master is the requesters/memory view.
interface imem_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CONT_WIDTH    = 16
);
  logic                     f_req;
  logic [ADDRESS_WIDTH-1:0] f_addr;
  logic                     f_gnt;
  logic                     f_rvalid;
  logic [DATA_WIDTH-1:0]    f_rdata;
  logic                     f_err;

  logic                     d_req;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic                     d_gnt;
  logic                     d_rvalid;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     d_err;

  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_rd;
  logic [CONT_WIDTH-1:0]    cont_cnt;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_rd,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_a, cont_cnt
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_a, cont_cnt
  );
endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. Grant is combinational; last_grant
// only moves when something is granted, so fetch wins the first contention after reset.
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_e      sel
);

  port_e r_last_grant;

  always_comb begin
    sel = PORT_F;
    unique case (req)
      2'b01:   sel = PORT_F;
      2'b10:   sel = PORT_D;
      2'b11:   sel = (r_last_grant == PORT_F) ? PORT_D : PORT_F;
      default: sel = PORT_F;
    endcase
    gnt = req & ((sel == PORT_D) ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_D;
    end else if (|req) begin
      r_last_grant <= sel;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one combinational instruction memory between fetch and data reads:
// address mux, registered per-port responses, misalign flags and a contention counter.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CONT_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  logic [1:0]               w_req;
  logic [1:0]               w_gnt;
  port_e                    w_sel;
  logic [ADDRESS_WIDTH-1:0] w_addr [2];

  logic [1:0]               r_rvalid;
  logic [1:0]               r_err;
  logic [DATA_WIDTH-1:0]    r_rdata [2];
  logic [CONT_WIDTH-1:0]    r_cont;

  assign w_req     = {bus.d_req, bus.f_req};
  assign w_addr[0] = bus.f_addr;
  assign w_addr[1] = bus.d_addr;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (w_req),
    .gnt (w_gnt),
    .sel (w_sel)
  );

  // With no request the selector rests on fetch, so mem_a follows f_addr.
  assign bus.mem_a = (w_sel == PORT_D) ? bus.d_addr : bus.f_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= '0;
      r_err    <= '0;
      for (int i = 0; i < 2; i++) begin
        r_rdata[i] <= '0;
      end
    end else begin
      r_rvalid <= w_gnt;
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) begin
          r_rdata[i] <= bus.mem_rd;
          r_err[i]   <= is_misaligned(w_addr[i][1:0]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cont <= '0;
    end else if (bus.f_req && bus.d_req && (r_cont != {CONT_WIDTH{1'b1}})) begin
      r_cont <= r_cont + {{(CONT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.f_gnt    = w_gnt[0];
  assign bus.d_gnt    = w_gnt[1];
  assign bus.f_rvalid = r_rvalid[0];
  assign bus.d_rvalid = r_rvalid[1];
  assign bus.f_rdata  = r_rdata[0];
  assign bus.d_rdata  = r_rdata[1];
  assign bus.f_err    = r_err[0];
  assign bus.d_err    = r_err[1];
  assign bus.cont_cnt = r_cont;

endmodule
